// File: rtl/ascii_cmd_parser_pkg.sv
// ascii_cmd_parser_pkg
// Shared definitions for the ASCII command path. The UART response sender
// uses the same command codes, mode encodings and ASCII constants.
//   - cmd_code_e     : decoded command identifiers
//   - ERR_*          : error codes reported with the error pulse
//   - MODE_*         : operating-mode encodings (W/S/H/D)
//   - ASCII_*        : characters recognised by the grammar
//   - parse_state_e  : line parser FSM states
//   - foldCase/isTerm/isDigit : character helpers
package ascii_cmd_parser_pkg;

  typedef enum logic [2:0] {
    CMD_QRY_TIME  = 3'd0,
    CMD_QRY_STATE = 3'd1,
    CMD_QRY_SR04  = 3'd2,
    CMD_QRY_DHT11 = 3'd3,
    CMD_SET_TIME  = 3'd4,
    CMD_SET_MODE  = 3'd5
  } cmd_code_e;

  localparam logic [1:0] ERR_SYNTAX  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam logic [1:0] MODE_W = 2'd0;
  localparam logic [1:0] MODE_S = 2'd1;
  localparam logic [1:0] MODE_H = 2'd2;
  localparam logic [1:0] MODE_D = 2'd3;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_T     = 8'h54;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_U     = 8'h55;
  localparam logic [7:0] ASCII_D     = 8'h44;
  localparam logic [7:0] ASCII_M     = 8'h4D;
  localparam logic [7:0] ASCII_W     = 8'h57;
  localparam logic [7:0] ASCII_H     = 8'h48;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GOT_T      = 3'd1,
    ST_TIME_FIELD = 3'd2,
    ST_MODE_ARG   = 3'd3,
    ST_WAIT_EOL   = 3'd4,
    ST_FLUSH      = 3'd5
  } parse_state_e;

  // Lower-case letters are folded to upper case so the grammar is case-insensitive.
  function automatic logic [7:0] foldCase(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
  endfunction

  function automatic logic isTerm(input logic [7:0] c);
    return (c == ASCII_CR) || (c == ASCII_LF);
  endfunction

  function automatic logic isDigit(input logic [7:0] c);
    return (c >= ASCII_0) && (c <= ASCII_9);
  endfunction

endpackage

// File: rtl/ascii_cmd_parser_if.sv
// ascii_cmd_parser_if
// Groups the byte stream from the UART RX core and the command/error outputs
// towards the control unit.
//   slave  : the parser side (consumes bytes and ready, drives command/error)
//   master : the environment side (drives bytes and ready)
interface ascii_cmd_parser_if;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        i_cmd_ready;
  logic        o_cmd_valid;
  logic [2:0]  o_cmd_code;
  logic [31:0] o_cmd_data;
  logic        o_err;
  logic [1:0]  o_err_code;
  logic        o_busy;

  modport slave (
    input  i_rx_data, i_rx_valid, i_cmd_ready,
    output o_cmd_valid, o_cmd_code, o_cmd_data, o_err, o_err_code, o_busy
  );

  modport master (
    output i_rx_data, i_rx_valid, i_cmd_ready,
    input  o_cmd_valid, o_cmd_code, o_cmd_data, o_err, o_err_code, o_busy
  );
endinterface

// File: rtl/ascii_cmd_parser_rx_idle_timer.sv
// ascii_cmd_parser_rx_idle_timer
// Inter-byte idle counter. Counts while enabled, restarts on clear, and
// pulses tick_o in the cycle the count reaches P_TIMEOUT_CYC-1.
//   iClk, iRstn : clock, asynchronous active-low reset
//   clear_i     : restart the count from zero
//   enable_i    : count this cycle
//   tick_o      : terminal-count pulse
module ascii_cmd_parser_rx_idle_timer #(
  parameter int P_TIMEOUT_CYC = 10_000_000
) (
  input  logic iClk,
  input  logic iRstn,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int W = (P_TIMEOUT_CYC > 2) ? $clog2(P_TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] TERMINAL = W'(P_TIMEOUT_CYC - 1);

  logic [W-1:0] count_q;

  assign tick_o = enable_i && !clear_i && (count_q == TERMINAL);

  // The count wraps to zero on the terminal tick so a stuck enable cannot
  // overflow.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      count_q <= '0;
    end else if (clear_i || tick_o) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/ascii_cmd_parser.sv
// ascii_cmd_parser
// Parses CR/LF-terminated ASCII command lines from the UART RX byte stream
// and presents one decoded command per valid line with a valid/ready hold.
//   iClk, iRstn : clock, asynchronous active-low reset
//   bus (slave) : i_rx_data/i_rx_valid byte stream, i_cmd_ready accept,
//                 o_cmd_valid/o_cmd_code/o_cmd_data command, o_err/o_err_code
//                 error pulse, o_busy (parser is mid-line)
module ascii_cmd_parser
  import ascii_cmd_parser_pkg::*;
#(
  parameter int P_TIMEOUT_CYC = 10_000_000
) (
  input  logic                iClk,
  input  logic                iRstn,
  ascii_cmd_parser_if.slave   bus
);

  parse_state_e state_q;
  logic [3:0]   idx_q;
  cmd_code_e    lineCode_q;
  logic [31:0]  lineData_q;

  logic         cmdValid_q;
  logic [2:0]   cmdCode_q;
  logic [31:0]  cmdData_q;
  logic         err_q;
  logic [1:0]   errCode_q;

  logic [7:0]   rxChar;
  logic         timeoutTick;
  logic         colonSlot;
  logic         lineDone;
  cmd_code_e    doneCode;
  logic [31:0]  doneData;

  assign rxChar    = foldCase(bus.i_rx_data);
  assign colonSlot = (idx_q == 4'd2) || (idx_q == 4'd5) || (idx_q == 4'd8);

  ascii_cmd_parser_rx_idle_timer #(
    .P_TIMEOUT_CYC(P_TIMEOUT_CYC)
  ) u_rx_idle_timer (
    .iClk     (iClk),
    .iRstn    (iRstn),
    .clear_i  (bus.i_rx_valid || (state_q == ST_IDLE)),
    .enable_i (state_q != ST_IDLE),
    .tick_o   (timeoutTick)
  );

  // A line completes on a terminator after a bare "T" or after a fully
  // parsed command. Query payloads are prepared when the line buffer is loaded.
  always_comb begin
    lineDone = 1'b0;
    doneCode = lineCode_q;
    doneData = lineData_q;
    if (bus.i_rx_valid && isTerm(rxChar)) begin
      if (state_q == ST_GOT_T) begin
        lineDone = 1'b1;
        doneCode = CMD_QRY_TIME;
        doneData = '0;
      end else if (state_q == ST_WAIT_EOL) begin
        lineDone = 1'b1;
      end
    end
  end

  // Parser FSM, line buffer and registered command/error outputs. A pending
  // command is only replaced once accepted; an accept in the completion cycle
  // frees the slot. A terminator that itself breaks the grammar ends the line
  // with a syntax error instead of waiting in FLUSH for another terminator.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      lineCode_q <= CMD_QRY_TIME;
      lineData_q <= '0;
      cmdValid_q <= 1'b0;
      cmdCode_q  <= '0;
      cmdData_q  <= '0;
      err_q      <= 1'b0;
      errCode_q  <= '0;
    end else begin
      err_q <= 1'b0;
      if (cmdValid_q && bus.i_cmd_ready) begin
        cmdValid_q <= 1'b0;
      end
      if (lineDone) begin
        if (!cmdValid_q || bus.i_cmd_ready) begin
          cmdValid_q <= 1'b1;
          cmdCode_q  <= doneCode;
          cmdData_q  <= doneData;
        end else begin
          err_q     <= 1'b1;
          errCode_q <= ERR_OVERRUN;
        end
      end
      if (timeoutTick) begin
        state_q   <= ST_IDLE;
        err_q     <= 1'b1;
        errCode_q <= ERR_TIMEOUT;
      end else if (bus.i_rx_valid) begin
        unique case (state_q)
          ST_IDLE: begin
            if (isTerm(rxChar)) begin
              state_q <= ST_IDLE;
            end else if (rxChar == ASCII_T) begin
              lineData_q <= '0;
              state_q    <= ST_GOT_T;
            end else if (rxChar == ASCII_S) begin
              lineCode_q <= CMD_QRY_STATE;
              lineData_q <= 32'd1;
              state_q    <= ST_WAIT_EOL;
            end else if (rxChar == ASCII_U) begin
              lineCode_q <= CMD_QRY_SR04;
              lineData_q <= 32'd2;
              state_q    <= ST_WAIT_EOL;
            end else if (rxChar == ASCII_D) begin
              lineCode_q <= CMD_QRY_DHT11;
              lineData_q <= 32'd3;
              state_q    <= ST_WAIT_EOL;
            end else if (rxChar == ASCII_M) begin
              state_q <= ST_MODE_ARG;
            end else begin
              state_q <= ST_FLUSH;
            end
          end
          ST_GOT_T: begin
            if (isTerm(rxChar)) begin
              state_q <= ST_IDLE;
            end else if (isDigit(rxChar)) begin
              lineData_q <= {lineData_q[27:0], rxChar[3:0]};
              idx_q      <= 4'd1;
              state_q    <= ST_TIME_FIELD;
            end else begin
              state_q <= ST_FLUSH;
            end
          end
          ST_TIME_FIELD: begin
            if (colonSlot ? (rxChar == ASCII_COLON) : isDigit(rxChar)) begin
              if (!colonSlot) begin
                lineData_q <= {lineData_q[27:0], rxChar[3:0]};
              end
              if (idx_q == 4'd10) begin
                lineCode_q <= CMD_SET_TIME;
                state_q    <= ST_WAIT_EOL;
              end else begin
                idx_q <= idx_q + 4'd1;
              end
            end else if (isTerm(rxChar)) begin
              err_q     <= 1'b1;
              errCode_q <= ERR_SYNTAX;
              state_q   <= ST_IDLE;
            end else begin
              state_q <= ST_FLUSH;
            end
          end
          ST_MODE_ARG: begin
            lineCode_q <= CMD_SET_MODE;
            state_q    <= ST_WAIT_EOL;
            if (rxChar == ASCII_W) begin
              lineData_q <= {30'd0, MODE_W};
            end else if (rxChar == ASCII_S) begin
              lineData_q <= {30'd0, MODE_S};
            end else if (rxChar == ASCII_H) begin
              lineData_q <= {30'd0, MODE_H};
            end else if (rxChar == ASCII_D) begin
              lineData_q <= {30'd0, MODE_D};
            end else if (isTerm(rxChar)) begin
              err_q     <= 1'b1;
              errCode_q <= ERR_SYNTAX;
              state_q   <= ST_IDLE;
            end else begin
              state_q <= ST_FLUSH;
            end
          end
          ST_WAIT_EOL: begin
            state_q <= isTerm(rxChar) ? ST_IDLE : ST_FLUSH;
          end
          ST_FLUSH: begin
            if (isTerm(rxChar)) begin
              err_q     <= 1'b1;
              errCode_q <= ERR_SYNTAX;
              state_q   <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.o_cmd_valid = cmdValid_q;
  assign bus.o_cmd_code  = cmdCode_q;
  assign bus.o_cmd_data  = cmdData_q;
  assign bus.o_err       = err_q;
  assign bus.o_err_code  = errCode_q;
  assign bus.o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ascii_cmd_parser.sv
// tb_ascii_cmd_parser
// Directed bench for ascii_cmd_parser. Expected commands and error codes are
// queued as lines are sent and checked when the parser presents them.
module tb_ascii_cmd_parser;
  import ascii_cmd_parser_pkg::*;

  localparam int P_TIMEOUT = 64;

  typedef struct packed {
    logic [2:0]  code;
    logic [31:0] data;
  } cmd_t;

  logic iClk = 1'b0;
  logic iRstn = 1'b0;

  ascii_cmd_parser_if bus();

  ascii_cmd_parser #(.P_TIMEOUT_CYC(P_TIMEOUT)) dut (
    .iClk  (iClk),
    .iRstn (iRstn),
    .bus   (bus)
  );

  always #5 iClk = ~iClk;

  int compareCount = 0;
  int mismatchCount = 0;
  cmd_t cmdQ[$];
  logic [1:0] errQ[$];
  cmd_t expCmd;
  logic [1:0] expErr;

  function automatic cmd_t mkCmd(input logic [2:0] code, input logic [31:0] data);
    cmd_t c;
    c.code = code;
    c.data = data;
    return c;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      mismatchCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(posedge iClk);
    #1;
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    @(posedge iClk);
    #1;
    bus.i_rx_valid = 1'b0;
  endtask

  // Sends the characters of s, then term unless term is zero.
  task automatic applyStimulus(input string s, input logic [7:0] term);
    for (int i = 0; i < s.len(); i++) begin
      sendByte(s[i]);
    end
    if (term != 8'h00) begin
      sendByte(term);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  // Scoreboard: a command is compared in the cycle it is accepted, an error
  // in the cycle it pulses. Anything arriving with an empty queue fails.
  always @(negedge iClk) begin
    if (iRstn && bus.o_cmd_valid && bus.i_cmd_ready) begin
      checkOutput("cmdExpected", 32'(cmdQ.size() != 0), 32'd1);
      if (cmdQ.size() != 0) begin
        expCmd = cmdQ.pop_front();
        checkOutput("cmdCode", 32'(bus.o_cmd_code), 32'(expCmd.code));
        checkOutput("cmdData", bus.o_cmd_data, expCmd.data);
      end
    end
    if (iRstn && bus.o_err) begin
      checkOutput("errExpected", 32'(errQ.size() != 0), 32'd1);
      if (errQ.size() != 0) begin
        expErr = errQ.pop_front();
        checkOutput("errCode", 32'(bus.o_err_code), 32'(expErr));
      end
    end
  end

  initial begin
    bus.i_rx_data   = 8'h00;
    bus.i_rx_valid  = 1'b0;
    bus.i_cmd_ready = 1'b0;
    waitCycles(3);
    checkOutput("rstValid", 32'(bus.o_cmd_valid), 32'd0);
    checkOutput("rstCode", 32'(bus.o_cmd_code), 32'd0);
    checkOutput("rstData", bus.o_cmd_data, 32'd0);
    checkOutput("rstErr", 32'(bus.o_err), 32'd0);
    checkOutput("rstErrCode", 32'(bus.o_err_code), 32'd0);
    checkOutput("rstBusy", 32'(bus.o_busy), 32'd0);
    iRstn = 1'b1;
    waitCycles(2);

    $display("[TB] step 1: T CR LF");
    bus.i_cmd_ready = 1'b1;
    cmdQ.push_back(mkCmd(3'd0, 32'd0));
    applyStimulus("T", ASCII_CR);
    sendByte(ASCII_LF);
    waitCycles(5);
    checkOutput("s1Drained", 32'(cmdQ.size()), 32'd0);
    checkOutput("s1Idle", 32'(bus.o_busy), 32'd0);

    $display("[TB] step 2: SET_TIME");
    cmdQ.push_back(mkCmd(3'd4, 32'h12345678));
    applyStimulus("t12:34:56:78", 8'h00);
    checkOutput("s2PreCrValid", 32'(bus.o_cmd_valid), 32'd0);
    sendByte(ASCII_CR);
    checkOutput("s2LatencyValid", 32'(bus.o_cmd_valid), 32'd1);
    checkOutput("s2LatencyCode", 32'(bus.o_cmd_code), 32'd4);
    waitCycles(3);
    checkOutput("s2Drained", 32'(cmdQ.size()), 32'd0);
    checkOutput("s2Dropped", 32'(bus.o_cmd_valid), 32'd0);

    $display("[TB] step 3: SET_MODE and QRY_SR04");
    cmdQ.push_back(mkCmd(3'd5, 32'd3));
    applyStimulus("Md", ASCII_LF);
    cmdQ.push_back(mkCmd(3'd2, 32'd2));
    applyStimulus("u", ASCII_CR);
    waitCycles(3);
    checkOutput("s3Drained", 32'(cmdQ.size()), 32'd0);

    $display("[TB] step 4: syntax errors then QRY_STATE");
    errQ.push_back(ERR_SYNTAX);
    applyStimulus("T12-34", ASCII_CR);
    errQ.push_back(ERR_SYNTAX);
    applyStimulus("X", ASCII_CR);
    waitCycles(2);
    checkOutput("s4ErrDrained", 32'(errQ.size()), 32'd0);
    checkOutput("s4NoCmd", 32'(bus.o_cmd_valid), 32'd0);
    cmdQ.push_back(mkCmd(3'd1, 32'd1));
    applyStimulus("S", ASCII_CR);
    waitCycles(3);
    checkOutput("s4Drained", 32'(cmdQ.size()), 32'd0);

    $display("[TB] step 5: timeout");
    applyStimulus("T12:3", 8'h00);
    checkOutput("s5BusyMidLine", 32'(bus.o_busy), 32'd1);
    errQ.push_back(ERR_TIMEOUT);
    waitCycles(2 * P_TIMEOUT + 10);
    checkOutput("s5TimeoutSeen", 32'(errQ.size()), 32'd0);
    checkOutput("s5BusyAfter", 32'(bus.o_busy), 32'd0);
    cmdQ.push_back(mkCmd(3'd3, 32'd3));
    applyStimulus("D", ASCII_CR);
    waitCycles(3);
    checkOutput("s5Drained", 32'(cmdQ.size()), 32'd0);

    $display("[TB] step 6: overrun, accept, reset mid-line");
    bus.i_cmd_ready = 1'b0;
    cmdQ.push_back(mkCmd(3'd1, 32'd1));
    applyStimulus("S", ASCII_CR);
    errQ.push_back(ERR_OVERRUN);
    applyStimulus("U", ASCII_CR);
    waitCycles(2);
    checkOutput("s6OverrunSeen", 32'(errQ.size()), 32'd0);
    checkOutput("s6HeldValid", 32'(bus.o_cmd_valid), 32'd1);
    checkOutput("s6HeldCode", 32'(bus.o_cmd_code), 32'd1);
    checkOutput("s6HeldData", bus.o_cmd_data, 32'd1);
    bus.i_cmd_ready = 1'b1;
    waitCycles(2);
    checkOutput("s6Accepted", 32'(cmdQ.size()), 32'd0);
    checkOutput("s6Dropped", 32'(bus.o_cmd_valid), 32'd0);
    bus.i_cmd_ready = 1'b0;
    cmdQ.push_back(mkCmd(3'd2, 32'd2));
    applyStimulus("U", ASCII_CR);
    applyStimulus("T12", 8'h00);
    checkOutput("s6BusyBeforeRst", 32'(bus.o_busy), 32'd1);
    checkOutput("s6PendingBeforeRst", 32'(bus.o_cmd_valid), 32'd1);
    #2;
    iRstn = 1'b0;
    #2;
    checkOutput("s6RstValid", 32'(bus.o_cmd_valid), 32'd0);
    checkOutput("s6RstCode", 32'(bus.o_cmd_code), 32'd0);
    checkOutput("s6RstData", bus.o_cmd_data, 32'd0);
    checkOutput("s6RstErrCode", 32'(bus.o_err_code), 32'd0);
    checkOutput("s6RstBusy", 32'(bus.o_busy), 32'd0);
    cmdQ.delete();
    waitCycles(2);
    iRstn = 1'b1;
    bus.i_cmd_ready = 1'b1;
    waitCycles(2 * P_TIMEOUT);
    checkOutput("s6NoSpuriousValid", 32'(bus.o_cmd_valid), 32'd0);
    checkOutput("s6NoSpuriousErr", 32'(errQ.size()), 32'd0);
    cmdQ.push_back(mkCmd(3'd0, 32'd0));
    applyStimulus("T", ASCII_CR);
    waitCycles(3);
    checkOutput("s6PostRstDrained", 32'(cmdQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
